// File: rtl/ram_arb_pkg.sv
// Types and constants for the fetch/execute RAM port arbiter.
//   word_t      : re-exported from rv32i_types_pkg so arbiter files need one import
//   arb_state_t : arbiter FSM states
//   FETCH_BE    : byte enables driven for every instruction fetch
package ram_arb_pkg;
   typedef rv32i_types_pkg::word_t word_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

   localparam logic [3:0] FETCH_BE = 4'hF;
endpackage

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I scalar types used across the core's memory-side blocks.
//   word_t : 32-bit machine word (addresses and data)
package rv32i_types_pkg;
   typedef logic [31:0] word_t;
endpackage

// File: rtl/arb_starve_counter.sv
// Fetch starvation guard for ram_port_arbiter (built only with
// RAM_ARB_STARVE_GUARD_EN).
// Counts data grants made while a fetch is waiting; once STARVE_LIMIT of them
// have gone by, force_i tells the arbiter to serve the fetch next.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   in_idle   : arbiter FSM is in IDLE this cycle
//   i_ren     : fetch request pending
//   grant_i   : arbiter grants the fetch this cycle
//   grant_d   : arbiter grants the data request this cycle
//   force_i   : fetch must win arbitration this cycle
module arb_starve_counter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic in_idle,
   input  logic i_ren,
   input  logic grant_i,
   input  logic grant_d,
   output logic force_i
);
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (grant_i || (in_idle && !i_ren)) begin
         cnt <= '0;
      end else if (grant_d && i_ren && (cnt != 4'hF)) begin
         // saturate so an out-of-range limit can never wrap back to zero
         cnt <= cnt + 4'd1;
      end
   end

   assign force_i = in_idle & i_ren & (cnt == LIMIT);
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-ported RAM bus between instruction fetch and the
// execute stage's data accesses, and produces the busy/stall signals the
// hazard unit consumes.
// Data requests win (they belong to the older instruction). Each access is
// followed by one IDLE bubble so a requester that has not yet dropped its
// request is not served twice.
// Optional build macro: RAM_ARB_STARVE_GUARD_EN -- after STARVE_LIMIT data
// grants with a fetch waiting, the fetch is served ahead of data.
// Ports:
//   CLK, RST                    : clock, asynchronous active-high reset
//   i_ren/i_addr                : fetch request; i_rdata/i_busy back to fetch
//   d_ren/d_wen/d_byte_en/
//   d_addr/d_wdata              : data request; d_rdata/d_busy back to execute
//   m_ren/m_wen/m_byte_en/
//   m_addr/m_wdata              : memory-side request
//   m_rdata/m_busy              : memory read data / access-not-done
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        i_ren,
   input  word_t       i_addr,
   output word_t       i_rdata,
   output logic        i_busy,
   input  logic        d_ren,
   input  logic        d_wen,
   input  logic [3:0]  d_byte_en,
   input  word_t       d_addr,
   input  word_t       d_wdata,
   output word_t       d_rdata,
   output logic        d_busy,
   output logic        m_ren,
   output logic        m_wen,
   output logic [3:0]  m_byte_en,
   output word_t       m_addr,
   output word_t       m_wdata,
   input  word_t       m_rdata,
   input  logic        m_busy
);
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("ram_port_arbiter: STARVE_LIMIT must be 1..15");
   end

   arb_state_t state;
   word_t      cap_addr;
   word_t      cap_wdata;
   logic [3:0] cap_be;
   logic       cap_wr;

   logic d_req;
   logic in_idle;
   logic grant_d;
   logic grant_i;
   logic force_i;

   assign d_req   = d_ren | d_wen;
   assign in_idle = (state == IDLE);
   assign grant_d = in_idle & d_req & ~force_i;
   assign grant_i = in_idle & i_ren & ~grant_d;

`ifdef RAM_ARB_STARVE_GUARD_EN
   arb_starve_counter #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk     (CLK),
      .rst     (RST),
      .in_idle (in_idle),
      .i_ren   (i_ren),
      .grant_i (grant_i),
      .grant_d (grant_d),
      .force_i (force_i)
   );
`else
   assign force_i = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_be    <= '0;
         cap_wr    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state     <= SERVE_D;
                  cap_addr  <= d_addr;
                  cap_wdata <= d_wdata;
                  cap_be    <= d_byte_en;
                  // read+write together is treated as a write
                  cap_wr    <= d_wen;
               end else if (grant_i) begin
                  state     <= SERVE_I;
                  cap_addr  <= i_addr;
                  cap_wdata <= '0;
                  cap_be    <= FETCH_BE;
                  cap_wr    <= 1'b0;
               end
            end
            // a flushed request still runs to completion; only m_busy ends it
            SERVE_I, SERVE_D: begin
               if (!m_busy) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // strobes are gated by state, so the async reset drops them at once
   assign m_ren     = (state == SERVE_I) | ((state == SERVE_D) & ~cap_wr);
   assign m_wen     = (state == SERVE_D) & cap_wr;
   assign m_byte_en = cap_be;
   assign m_addr    = cap_addr;
   assign m_wdata   = cap_wdata;

   assign i_busy  = i_ren & ~((state == SERVE_I) & ~m_busy);
   assign d_busy  = d_req & ~((state == SERVE_D) & ~m_busy);
   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;
endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
   logic        CLK;
   logic        RST;
   logic        i_ren;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_busy;
   logic        d_ren;
   logic        d_wen;
   logic [3:0]  d_byte_en;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_busy;
   logic        m_ren;
   logic        m_wen;
   logic [3:0]  m_byte_en;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_busy;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic        is_fetch;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } exp_t;

   exp_t sb[$];

   ram_port_arbiter #(.STARVE_LIMIT(2)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .i_ren     (i_ren),
      .i_addr    (i_addr),
      .i_rdata   (i_rdata),
      .i_busy    (i_busy),
      .d_ren     (d_ren),
      .d_wen     (d_wen),
      .d_byte_en (d_byte_en),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_busy    (d_busy),
      .m_ren     (m_ren),
      .m_wen     (m_wen),
      .m_byte_en (m_byte_en),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_rdata   (m_rdata),
      .m_busy    (m_busy)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   assign m_rdata = mem_word(m_addr);

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic sample();
      @(negedge CLK);
   endtask

   task automatic push(input logic f, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
      exp_t e;
      e.is_fetch = f;
      e.wr       = w;
      e.addr     = a;
      e.wdata    = wd;
      e.be       = be;
      sb.push_back(e);
   endtask

   // scoreboard: every completing memory access must match the next expected one
   always @(negedge CLK) begin : monitor
      exp_t e;
      if (!RST && (m_ren || m_wen) && !m_busy) begin
         if (sb.size() == 0) begin
            check("sb_extra_access", 32'(m_addr != m_addr) + 1, 0);
         end else begin
            e = sb.pop_front();
            check("sb_addr", m_addr, e.addr);
            check("sb_wen", 32'(m_wen), 32'(e.wr));
            check("sb_ren", 32'(m_ren), 32'(!e.wr));
            check("sb_be", 32'(m_byte_en), 32'(e.be));
            if (e.wr) check("sb_wdata", m_wdata, e.wdata);
            if (e.is_fetch) begin
               check("sb_i_busy", 32'(i_busy), 0);
               check("sb_i_rdata", i_rdata, mem_word(e.addr));
            end else begin
               check("sb_d_busy", 32'(d_busy), 0);
               if (!e.wr) check("sb_d_rdata", d_rdata, mem_word(e.addr));
            end
         end
      end
   end

   initial begin
      RST = 1'b1; i_ren = 0; i_addr = 0; d_ren = 0; d_wen = 0;
      d_byte_en = 0; d_addr = 0; d_wdata = 0; m_busy = 0;

      // reset state
      repeat (2) @(posedge CLK);
      sample();
      check("rst_m_ren", 32'(m_ren), 0);
      check("rst_m_wen", 32'(m_wen), 0);
      check("rst_m_addr", m_addr, 0);
      check("rst_m_wdata", m_wdata, 0);
      check("rst_m_be", 32'(m_byte_en), 0);
      check("rst_i_busy", 32'(i_busy), 0);
      step(); RST = 1'b0;
      sample();
      check("rst_idle", 32'(m_ren | m_wen), 0);

      // fetch only, zero wait states
      step(); i_ren = 1; i_addr = 32'h200; m_busy = 0;
      push(1, 0, 32'h200, 0, 4'hF);
      sample();
      check("t1_c0_i_busy", 32'(i_busy), 1);
      check("t1_c0_m_ren", 32'(m_ren), 0);
      step(); sample();
      check("t1_c1_m_ren", 32'(m_ren), 1);
      check("t1_c1_m_addr", m_addr, 32'h200);
      check("t1_c1_m_be", 32'(m_byte_en), 32'hF);
      check("t1_c1_i_busy", 32'(i_busy), 0);
      check("t1_c1_i_rdata", i_rdata, mem_word(32'h200));
      step(); i_ren = 0; sample();
      check("t1_c2_idle", 32'(m_ren | m_wen), 0);

      // simultaneous fetch and data write: data first
      step(); i_ren = 1; i_addr = 32'h300;
      d_wen = 1; d_addr = 32'h1000; d_wdata = 32'hDEADBEEF; d_byte_en = 4'h3;
      push(0, 1, 32'h1000, 32'hDEADBEEF, 4'h3);
      push(1, 0, 32'h300, 0, 4'hF);
      sample();
      check("t2_c0_i_busy", 32'(i_busy), 1);
      check("t2_c0_d_busy", 32'(d_busy), 1);
      step(); sample();
      check("t2_c1_m_wen", 32'(m_wen), 1);
      check("t2_c1_m_ren", 32'(m_ren), 0);
      check("t2_c1_m_wdata", m_wdata, 32'hDEADBEEF);
      check("t2_c1_m_be", 32'(m_byte_en), 32'h3);
      check("t2_c1_i_busy", 32'(i_busy), 1);
      check("t2_c1_d_busy", 32'(d_busy), 0);
      step(); d_wen = 0; sample();
      check("t2_c2_bubble", 32'(m_ren | m_wen), 0);
      check("t2_c2_i_busy", 32'(i_busy), 1);
      step(); sample();
      check("t2_c3_m_ren", 32'(m_ren), 1);
      check("t2_c3_m_addr", m_addr, 32'h300);
      check("t2_c3_i_busy", 32'(i_busy), 0);
      step(); i_ren = 0; sample();
      check("t2_c4_idle", 32'(m_ren | m_wen), 0);

      // data read with three wait states
      step(); d_ren = 1; d_addr = 32'h2000; d_byte_en = 4'hF; m_busy = 1;
      push(0, 0, 32'h2000, 0, 4'hF);
      sample();
      for (int k = 0; k < 3; k++) begin
         step(); sample();
         check("t3_wait_d_busy", 32'(d_busy), 1);
         check("t3_wait_m_ren", 32'(m_ren), 1);
         check("t3_wait_m_addr", m_addr, 32'h2000);
         check("t3_wait_m_be", 32'(m_byte_en), 32'hF);
      end
      step(); m_busy = 0; sample();
      check("t3_done_d_busy", 32'(d_busy), 0);
      step(); d_ren = 0; sample();
      check("t3_after_idle", 32'(m_ren | m_wen), 0);

      // fetch flushed while memory is busy
      step(); i_ren = 1; i_addr = 32'h400; m_busy = 1;
      push(1, 0, 32'h400, 0, 4'hF);
      sample();
      step(); sample();
      check("t4_grant_m_ren", 32'(m_ren), 1);
      step(); i_ren = 0; sample();
      check("t4_flush_m_ren", 32'(m_ren), 1);
      check("t4_flush_m_addr", m_addr, 32'h400);
      step(); m_busy = 0; sample();
      check("t4_complete_m_ren", 32'(m_ren), 1);
      step(); sample();
      check("t4_idle", 32'(m_ren), 0);
      step(); sample();
      check("t4_no_refetch", 32'(m_ren), 0);

      // reset pulse in the middle of a fetch
      step(); i_ren = 1; i_addr = 32'h500; m_busy = 1;
      push(1, 0, 32'h500, 0, 4'hF);
      sample();
      step(); sample();
      check("t5_pre_m_ren", 32'(m_ren), 1);
      #2 RST = 1'b1;
      #1;
      check("t5_async_m_ren", 32'(m_ren), 0);
      check("t5_async_m_addr", m_addr, 0);
      check("t5_async_m_be", 32'(m_byte_en), 0);
      sb.delete();
      i_ren = 0; m_busy = 0;
      step(); RST = 1'b0; sample();
      check("t5_post_idle", 32'(m_ren | m_wen), 0);
      step(); i_ren = 1; i_addr = 32'h700;
      push(1, 0, 32'h700, 0, 4'hF);
      sample();
      step(); sample();
      check("t5_refetch_m_ren", 32'(m_ren), 1);
      check("t5_refetch_m_addr", m_addr, 32'h700);
      step(); i_ren = 0; sample();

      // continuous data and fetch pressure: grant order via scoreboard
      step(); d_ren = 1; d_addr = 32'h3000; d_byte_en = 4'hF;
      i_ren = 1; i_addr = 32'h600; m_busy = 0;
`ifdef RAM_ARB_STARVE_GUARD_EN
      push(0, 0, 32'h3000, 0, 4'hF); push(0, 0, 32'h3000, 0, 4'hF);
      push(1, 0, 32'h600, 0, 4'hF);
      push(0, 0, 32'h3000, 0, 4'hF); push(0, 0, 32'h3000, 0, 4'hF);
      push(1, 0, 32'h600, 0, 4'hF);
`else
      for (int k = 0; k < 6; k++) push(0, 0, 32'h3000, 0, 4'hF);
`endif
      for (int c = 0; c < 12; c++) begin
         sample();
`ifndef RAM_ARB_STARVE_GUARD_EN
         check("t6_i_starved", 32'(i_busy), 1);
`endif
         if (c < 11) step();
      end
      step(); d_ren = 0; i_ren = 0; sample();
      check("t6_idle", 32'(m_ren | m_wen), 0);

      check("sb_drain", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
